// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full adder reused across WIDTH bit
// positions, LSB first, with a carry flop closing the loop between cycles.
// fa_v1 is kept in this file so the block is self-contained.

module fa_v1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned    CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  // Encoding chosen so busy and done are straight flop bits.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  ra_q, ra_d;
  logic [WIDTH-1:0]  rb_q, rb_d;
  logic [WIDTH-1:0]  racc_q, racc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_q, c_d;
  logic              cout_q, cout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fa_sum, fa_cout;
  logic [WIDTH:0]    racc_ext;

  fa_v1 u_fa (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New bit enters at the MSB; slicing the extended vector also works for WIDTH=1.
  assign racc_ext = {fa_sum, racc_q};

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    racc_d  = racc_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          racc_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        racc_d = racc_ext[WIDTH:1];
        ra_d   = ra_q >> 1;
        rb_d   = rb_q >> 1;
        c_d    = fa_cout;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = racc_ext[WIDTH:1];
          cout_d  = fa_cout;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      racc_q  <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      racc_q  <= racc_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = state_q[1];
  assign done = state_q[0];
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
// Expected results come from plain a+b+cin arithmetic and cycle counting.

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       rst1, start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst8),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst1),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation from IDLE; operands are scrambled while busy.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input string tag);
    logic [8:0] exp;
    int lat, bcnt;
    exp    = 9'(ta) + 9'(tb) + 9'(tc);
    a8     = ta;
    b8     = tb;
    cin8   = tc;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat    = 1;
    bcnt   = 0;
    while (!done8 && lat < 20) begin
      bcnt += int'(busy8);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      step();
      lat++;
    end
    bcnt += int'(busy8);
    check({tag, " latency"}, 64'(lat), 64'd9);
    check({tag, " busy_cycles"}, 64'(bcnt), 64'd9);
    check({tag, " sum"}, 64'(sum8), 64'(exp[7:0]));
    check({tag, " cout"}, 64'(cout8), 64'(exp[8]));
    step();
    check({tag, " idle_after"}, 64'({busy8, done8}), 64'd0);
  endtask

  task automatic op1(input logic ta, input logic tb, input logic tc);
    logic [1:0] exp;
    int lat;
    exp    = 2'(ta) + 2'(tb) + 2'(tc);
    a1     = ta;
    b1     = tb;
    cin1   = tc;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    lat    = 1;
    while (!done1 && lat < 10) begin
      step();
      lat++;
    end
    check($sformatf("w1 %0d%0d%0d latency", ta, tb, tc), 64'(lat), 64'd2);
    check($sformatf("w1 %0d%0d%0d result", ta, tb, tc), 64'({cout1, sum1}), 64'(exp));
    step();
  endtask

  initial begin
    int dcnt, cyc, hold_bad, guard;
    logic prev_busy, first_done;
    int rises[$];

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    step();
    step();
    rst8 = 1'b0;
    rst1 = 1'b0;

    // Reset state
    check("reset busy", 64'(busy8), 64'd0);
    check("reset done", 64'(done8), 64'd0);
    check("reset sum", 64'(sum8), 64'd0);
    check("reset cout", 64'(cout8), 64'd0);

    // Directed operations
    op8(8'h00, 8'h00, 1'b0, "zero");
    op8(8'hFF, 8'h01, 1'b0, "ff_01");
    op8(8'h5A, 8'hA5, 1'b1, "5a_a5_c");
    op8(8'h12, 8'h34, 1'b1, "12_34_c");

    // start pulsed during RUN and DONE must be ignored
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    dcnt = 0;
    a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      start8 = (i % 2 == 0) || (i == 8);
      dcnt += int'(done8);
      step();
    end
    start8 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      dcnt += int'(done8);
      step();
    end
    check("ignored_start done_count", 64'(dcnt), 64'd1);
    check("ignored_start sum", 64'(sum8), 64'h10);
    check("ignored_start cout", 64'(cout8), 64'd0);
    check("ignored_start idle", 64'(busy8), 64'd0);

    // start held high: sum holds prior value, acceptances 10 cycles apart
    a8 = 8'h20; b8 = 8'h30; cin8 = 1'b0; start8 = 1'b1;
    prev_busy = busy8;
    first_done = 1'b0;
    hold_bad = 0;
    for (cyc = 1; cyc <= 35; cyc++) begin
      step();
      if (busy8 && !prev_busy) rises.push_back(cyc);
      if (!first_done && !done8 && sum8 !== 8'h10) hold_bad++;
      if (done8) first_done = 1'b1;
      prev_busy = busy8;
    end
    start8 = 1'b0;
    guard = 0;
    while (busy8 && guard < 20) begin
      step();
      guard++;
    end
    check("held sum_hold_violations", 64'(hold_bad), 64'd0);
    check("held acceptances", 64'(rises.size()), 64'd4);
    if (rises.size() >= 3) begin
      check("held gap1", 64'(rises[1] - rises[0]), 64'd10);
      check("held gap2", 64'(rises[2] - rises[1]), 64'd10);
    end
    check("held drained", 64'(busy8), 64'd0);
    check("held sum", 64'(sum8), 64'h50);

    // Reset on the 4th RUN cycle aborts without a done pulse
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
    check("abort busy", 64'(busy8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    check("abort sum", 64'(sum8), 64'd0);
    check("abort cout", 64'(cout8), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      dcnt += int'(done8) + int'(busy8);
      step();
    end
    check("abort no_activity", 64'(dcnt), 64'd0);

    // rst and start on the same edge: request dropped
    a8 = 8'h77; b8 = 8'h11; rst8 = 1'b1; start8 = 1'b1;
    step();
    rst8 = 1'b0;
    start8 = 1'b0;
    check("rst_start busy", 64'(busy8), 64'd0);
    step();
    check("rst_start still_idle", 64'(busy8), 64'd0);
    op8(8'h01, 8'h01, 1'b0, "post_abort");

    // Random operations
    for (int i = 0; i < 12; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    // WIDTH=1 exhaustive
    for (int v = 0; v < 8; v++) begin
      op1(v[2], v[1], v[0]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
